valid_array_ctrl: RTL
=====================

# valid_array_ctrl

Single-port access controller for the `valid_array` macro. It arbitrates between a lookup requester (cache pipeline tag/valid check) and an update requester (fill/invalidate), and sequences whole-array flushes. It drives the array's active-low chip-select/write-enable interface and returns lookup data with fixed one-cycle latency.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive update-caused lookup losses before lookup is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lkp_req  in  1  lookup request; held until granted.
- lkp_set  in  S_INDEX  lookup set; stable while lkp_req high.
- lkp_gnt  out  1  lookup issued this cycle.
- lkp_rsp_valid  out  1  lookup data valid this cycle.
- lkp_rsp_data  out  VALIDARR_WIDTH  lookup data; 0 when lkp_rsp_valid low.
- upd_req  in  1  write request; held until granted.
- upd_set  in  S_INDEX  write set.
- upd_data  in  VALIDARR_WIDTH  write data.
- upd_gnt  out  1  write issued this cycle.
- flush_req  in  1  flush request pulse.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse at flush completion.
- arr_csb0  out  1  array chip select, active low.
- arr_web0  out  1  array write enable, active low.
- arr_addr0  out  S_INDEX  array address.
- arr_din0  out  VALIDARR_WIDTH  array write data.
- arr_dout0  in  VALIDARR_WIDTH  array read data.

## Operation
- States: IDLE, FLUSH.
- IDLE priority: flush_req > forced lookup (starve count == STARVE_LIMIT) > update > lookup. At most one grant per cycle; grants are combinational in the request cycle.
- A flush_req in IDLE issues no grant that cycle. The state moves to FLUSH at the next edge with flush counter = 0.
- FLUSH: one write of all-zero data per cycle to set = counter. The counter increments each cycle. No lkp_gnt or upd_gnt is issued; flush_busy = 1.
- When the write to set NUM_SETS-1 issues, the state returns to IDLE at that edge. flush_done pulses in the following cycle, which is also the first cycle in which grants are possible.
- flush_req while in FLUSH is ignored; no queuing.
- Starve counter:
  - Increments when lkp_req is high and the lookup loses to upd_req.
  - Clears on lkp_gnt.
  - Holds during FLUSH and during flush_req cycles.
  - Saturates at STARVE_LIMIT; width is $clog2(STARVE_LIMIT+1).
- Array drive:
  - Lookup: csb0 = 0, web0 = 1, addr0 = lkp_set.
  - Update: csb0 = 0, web0 = 0, addr0 = upd_set, din0 = upd_data.
  - Flush: csb0 = 0, web0 = 0, addr0 = counter, din0 = 0.
  - Otherwise: csb0 = 1, web0 = 1, addr0 = 0, din0 = 0.
- lkp_rsp_valid = lkp_gnt registered. lkp_rsp_data = arr_dout0 gated by lkp_rsp_valid.

## Timing
- Lookup latency: data arrives exactly 1 cycle after lkp_gnt. There are no stalls on the response path, and the consumer must sample it in that cycle.
- Write visibility: an update granted in cycle N is returned by any lookup granted in cycle N+1 or later. No forwarding is needed because the array registers inputs and reads combinationally.
- Flush duration: flush_busy is high for exactly NUM_SETS cycles. The first lookup after flush_done returns 0.
- Reset: state IDLE, counters 0, all grants/valid/busy/done 0, arr_csb0 = arr_web0 = 1, addr/din 0.
- rst mid-flush aborts the flush with no flush_done. The array is cleared by its own reset.

## Configuration
- VALID_ARRAY_CTRL_FLUSH_EN defined: FLUSH state, flush counter and flush outputs behave as above.
- VALID_ARRAY_CTRL_FLUSH_EN undefined: flush_req is ignored, and flush_busy and flush_done are tied to 0. The controller is a stateless-arbiter plus starve counter.

## Structure
- S_INDEX, VALIDARR_WIDTH and NUM_SETS come from package CDB_types.
- A ctrl_state_t enum {IDLE, FLUSH} is added to CDB_types.
- One sub-module, valid_flush_seq: owns the state, the flush counter, flush_busy and flush_done, and exports the flush write address/enable. It is instantiated only under VALID_ARRAY_CTRL_FLUSH_EN.
- The valid_array instance is external; the bench connects the two.

## Test plan
- Lookup only: write set 3 = 1, then lkp_req set 3 -> lkp_gnt same cycle; next cycle lkp_rsp_valid = 1, lkp_rsp_data = 1.
- Back-to-back write then read: upd set 5 = 1 in cycle N, lkp set 5 in N+1 -> rsp_data = 1 in N+2.
- Contention: lkp_req and upd_req held high with STARVE_LIMIT = 4 -> 4 consecutive upd_gnt, then lkp_gnt, then upd_gnt resumes; lkp_gnt and upd_gnt never high together.
- Flush with S_INDEX = 4: all sets pre-written to 1, then flush_req pulse -> flush_busy high for 16 cycles, arr_addr0 steps 0..15 with web0 = 0 and din0 = 0, flush_done pulses once. Subsequent lookups of all sets return 0.
- Requests during flush: lkp_req and upd_req held through the flush -> no grants while busy; upd_gnt in the flush_done cycle.
- Reset at flush counter 7 -> all outputs at reset values the next cycle, no flush_done.

Source files
------------

// File: rtl/valid_array_ctrl_pkg.sv
// Shared types and geometry for the valid_array controller slice.
// The flush feature is enabled with VALID_ARRAY_CTRL_FLUSH_EN.
package CDB_types;

    localparam int S_INDEX        = 4;
    localparam int NUM_SETS       = 1 << S_INDEX;
    localparam int VALIDARR_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/valid_array_ctrl_flush.sv
// Flush sequencer: walks every set once, writing zero, then pulses flush_done.
// Only instantiated when VALID_ARRAY_CTRL_FLUSH_EN is defined.
module valid_flush_seq
    import CDB_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req_i,
    output logic               flush_busy_o,
    output logic               flush_done_o,
    output logic               flush_we_o,
    output logic [S_INDEX-1:0] flush_addr_o,
    output ctrl_state_t        state_o
);

    ctrl_state_t        state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                // Leave on the edge that issues the last set's write.
                if (cnt_q == S_INDEX'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign flush_busy_o = (state_q == FLUSH);
    assign flush_we_o   = (state_q == FLUSH);
    assign flush_addr_o = cnt_q;
    assign flush_done_o = done_q;
    assign state_o      = state_q;

endmodule

// File: rtl/valid_array_ctrl.sv
// Single-port access controller for valid_array: lookup/update arbitration with
// starvation guard, optional whole-array flush under VALID_ARRAY_CTRL_FLUSH_EN.
module valid_array_ctrl
    import CDB_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lkp_req,
    input  logic [S_INDEX-1:0]        lkp_set,
    output logic                      lkp_gnt,
    output logic                      lkp_rsp_valid,
    output logic [VALIDARR_WIDTH-1:0] lkp_rsp_data,
    input  logic                      upd_req,
    input  logic [S_INDEX-1:0]        upd_set,
    input  logic [VALIDARR_WIDTH-1:0] upd_data,
    output logic                      upd_gnt,
    input  logic                      flush_req,
    output logic                      flush_busy,
    output logic                      flush_done,
    output logic                      arr_csb0,
    output logic                      arr_web0,
    output logic [S_INDEX-1:0]        arr_addr0,
    output logic [VALIDARR_WIDTH-1:0] arr_din0,
    input  logic [VALIDARR_WIDTH-1:0] arr_dout0,
    output ctrl_state_t               dbg_state
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    logic               block;
    logic               fl_we;
    logic [S_INDEX-1:0] fl_addr;
    logic [SW-1:0]      starve_q, starve_d;
    logic               rsp_valid_q;
    logic               forced;

`ifdef VALID_ARRAY_CTRL_FLUSH_EN
    valid_flush_seq u_flush (
        .clk          (clk),
        .rst          (rst),
        .flush_req_i  (flush_req),
        .flush_busy_o (flush_busy),
        .flush_done_o (flush_done),
        .flush_we_o   (fl_we),
        .flush_addr_o (fl_addr),
        .state_o      (dbg_state)
    );
    // A flush request cycle in IDLE is dead: no grant, starve counter holds.
    assign block = flush_busy | flush_req;
`else
    logic unused_flush_req;
    assign unused_flush_req = flush_req;
    assign flush_busy       = 1'b0;
    assign flush_done       = 1'b0;
    assign fl_we            = 1'b0;
    assign fl_addr          = '0;
    assign dbg_state        = IDLE;
    assign block            = 1'b0;
`endif

    assign forced  = (starve_q == STARVE_MAX);
    assign lkp_gnt = !block && lkp_req && (forced || !upd_req);
    assign upd_gnt = !block && upd_req && !lkp_gnt;

    always_comb begin
        starve_d = starve_q;
        if (!block) begin
            if (lkp_gnt)
                starve_d = '0;
            else if (lkp_req && upd_gnt && !forced)
                starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        arr_csb0  = 1'b1;
        arr_web0  = 1'b1;
        arr_addr0 = '0;
        arr_din0  = '0;
        if (fl_we) begin
            arr_csb0  = 1'b0;
            arr_web0  = 1'b0;
            arr_addr0 = fl_addr;
        end else if (lkp_gnt) begin
            arr_csb0  = 1'b0;
            arr_addr0 = lkp_set;
        end else if (upd_gnt) begin
            arr_csb0  = 1'b0;
            arr_web0  = 1'b0;
            arr_addr0 = upd_set;
            arr_din0  = upd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            rsp_valid_q <= lkp_gnt;
        end
    end

    assign lkp_rsp_valid = rsp_valid_q;
    assign lkp_rsp_data  = rsp_valid_q ? arr_dout0 : '0;

endmodule
